// File: rtl/hamming_corrector_display.sv
// hamming_corrector_display
// Final stage of a Hamming(8,4) SECDED receive path. A button press captures the
// received word and its syndrome. The block classifies the error and corrects a
// single-bit error. It holds the result and scans it onto two 7-segment digits.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   boton         capture request (debounced, asynchronous level)
//   conmutador_8  received word {g0,w3,w2,w1,p2,w0,p1,p0}
//   sindrome      syndrome {g1,c2,c1,c0}
//   dato_corr     corrected data {w3,w2,w1,w0}
//   clase_error   00 none, 01 single corrected, 10 double detected
//   pos_error     0 none, 1..7 bit index+1, 8 = g0
//   valido        result valid
//   seg           segments {g,f,e,d,c,b,a}, active-low
//   an            digit enables, active-low; an[0] data digit, an[1] position digit
module hamming_corrector_display #(
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boton,
  input  logic [7:0] conmutador_8,
  input  logic [3:0] sindrome,
  output logic [3:0] dato_corr,
  output logic [1:0] clase_error,
  output logic [3:0] pos_error,
  output logic       valido,
  output logic [6:0] seg,
  output logic [1:0] an
);

  typedef enum logic [1:0] {StIdle, StCapture, StEval, StDone} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              pulse;
  logic [7:0]        word_q;
  logic [3:0]        sind_q;
  logic [3:0]        dato_q, dato_d;
  logic [1:0]        clase_q, clase_d;
  logic [3:0]        pos_q, pos_d;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Rising edge of the synchronised button; one cycle wide.
  assign pulse = sync2_q & ~prev_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (pulse) state_d = StCapture;
      StCapture: state_d = StEval;
      StEval:    state_d = StDone;
      StDone:    if (pulse) state_d = StCapture;
      default:   state_d = StIdle;
    endcase
  end

  // Classification from the latched copies. c selects the failing bit (index c-1);
  // par is the overall parity including g0.
  always_comb begin
    logic [2:0] c;
    logic       par;
    logic [7:0] fixed;
    c       = sind_q[2:0];
    par     = sind_q[3] ^ word_q[7];
    fixed   = word_q;
    clase_d = 2'b00;
    pos_d   = 4'd0;
    if (c != 3'd0 && par) begin
      fixed   = word_q ^ (8'd1 << (c - 3'd1));
      clase_d = 2'b01;
      pos_d   = {1'b0, c};
    end else if (c == 3'd0 && par) begin
      clase_d = 2'b01;
      pos_d   = 4'd8;
    end else if (c != 3'd0 && !par) begin
      clase_d = 2'b10;
    end
    dato_d = {fixed[6], fixed[5], fixed[4], fixed[2]};
  end

  always_comb begin
    an_d = cnt_q[REFRESH_BITS-1] ? 2'b01 : 2'b10;
    if (state_q != StDone) begin
      seg_d = 7'h7F;
    end else if (!cnt_q[REFRESH_BITS-1]) begin
      seg_d = hex7(dato_q);
    end else if (clase_q == 2'b10) begin
      seg_d = 7'h21;
    end else begin
      seg_d = hex7(pos_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      word_q  <= 8'h00;
      sind_q  <= 4'h0;
      dato_q  <= 4'h0;
      clase_q <= 2'b00;
      pos_q   <= 4'h0;
      cnt_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= 2'b11;
    end else begin
      state_q <= state_d;
      sync1_q <= boton;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_q + REFRESH_BITS'(1);
      seg_q   <= seg_d;
      an_q    <= an_d;
      if (state_q == StCapture) begin
        word_q <= conmutador_8;
        sind_q <= sindrome;
      end
      if (state_q == StEval) begin
        dato_q  <= dato_d;
        clase_q <= clase_d;
        pos_q   <= pos_d;
      end
    end
  end

  assign dato_corr   = dato_q;
  assign clase_error = clase_q;
  assign pos_error   = pos_q;
  assign valido      = (state_q == StDone);
  assign seg         = seg_q;
  assign an          = an_q;

endmodule
